// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per shift_en tick, MSB-first or LSB-first. Back-to-back words load at
// the last-bit tick with no idle gap. All serial outputs are registered.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             sout_q,  sout_d;
    logic             valid_q, valid_d;
    logic             sof_q,   sof_d;
    logic             eof_q,   eof_d;
    logic             load_s;
    logic             last_s;

    // Bit that goes on the line next, taken from the end of the shift register
    // that faces the serial output.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        logic b;
        if (MSB_FIRST) begin
            b = w[WIDTH-1];
        end else begin
            b = w[0];
        end
        return b;
    endfunction

    // Advance the shift register by one bit toward the serial output end.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {w[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, w[WIDTH-1:1]};
        end
        return r;
    endfunction

    assign last_s    = (cnt_q == LAST);
    // Ready in IDLE, or on the tick that completes the last bit of a word.
    assign din_ready = (state_q == IDLE) || ((state_q == SHIFT) && shift_en && last_s);
    assign load_s    = din_valid && din_ready;

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign busy       = valid_q;

    // Next-state logic: load, shift, word completion and the derived output bits.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_s) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (last_s) begin
                        if (load_s) begin
                            state_d = SHIFT;
                            shreg_d = din;
                        end else begin
                            state_d = IDLE;
                            shreg_d = {WIDTH{1'b0}};
                        end
                        cnt_d = ZERO;
                    end else begin
                        shreg_d = shift_once(shreg_q);
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = {WIDTH{1'b0}};
                cnt_d   = ZERO;
            end
        endcase

        valid_d = (state_d == SHIFT);
        sout_d  = valid_d ? head_bit(shreg_d) : 1'b0;
        sof_d   = valid_d && (cnt_d == ZERO);
        eof_d   = valid_d && (cnt_d == LAST);
    end

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= ZERO;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 din  input  WIDTH  parallel word to serialize; sampled only on a load handshake.
REQ-006 din_valid  input  1  din holds a word to send.
REQ-007 din_ready  output  1  block accepts din this cycle; combinational from state, bit_cnt and shift_en.
REQ-008 shift_en  input  1  bit-rate tick; the current bit is complete at the edge ending a cycle with shift_en=1.
REQ-009 sout  output  1  serial data, registered.
REQ-010 sout_valid  output  1  sout carries a word bit.
REQ-011 sof  output  1  sout carries the first bit of a word.
REQ-012 eof  output  1  sout carries the last bit of a word.
REQ-013 busy  output  1  word in progress; equals sout_valid.

Function
REQ-014 The block SHALL have two states: IDLE and SHIFT.
REQ-015 The block SHALL hold a WIDTH-bit shift register and a bit counter bit_cnt of ceil(log2(WIDTH)) bits.
REQ-016 Load handshake: a word SHALL be accepted at a rising edge where din_valid=1 and din_ready=1.
REQ-017 din_ready SHALL be 1 in IDLE, and in SHIFT only when shift_en=1 and bit_cnt=WIDTH-1; otherwise 0.
REQ-018 On a load, the block SHALL capture din, set bit_cnt=0 and enter or remain in SHIFT.
REQ-019 The first bit SHALL appear on sout in the cycle immediately after the load edge (latency 1 cycle).
REQ-020 In SHIFT, sout SHALL be din[WIDTH-1-bit_cnt] when MSB_FIRST=1, and din[bit_cnt] when MSB_FIRST=0.
REQ-021 In SHIFT, each bit SHALL be held until an edge with shift_en=1; at that edge bit_cnt increments and the register shifts by one.
REQ-022 With shift_en=0, all state and outputs SHALL hold.
REQ-023 At an edge in SHIFT with shift_en=1 and bit_cnt=WIDTH-1: if din_valid=1, a new word SHALL load with no idle gap; otherwise the state SHALL go to IDLE.
REQ-024 sout_valid and busy SHALL be 1 exactly in SHIFT.
REQ-025 sof SHALL be sout_valid AND bit_cnt=0.
REQ-026 eof SHALL be sout_valid AND bit_cnt=WIDTH-1.
REQ-027 In IDLE, sout, sout_valid, sof, eof and busy SHALL be 0.
REQ-028 Changes on din or din_valid while din_ready=0 SHALL have no effect; the word in flight is never corrupted.
REQ-029 shift_en SHALL have no effect in IDLE; a load SHALL NOT require shift_en=1.

Reset
REQ-030 When rst=0, the block SHALL immediately (asynchronously) force IDLE, the shift register to 0, bit_cnt to 0, and sout, sout_valid, sof, eof and busy to 0.
REQ-031 No load SHALL occur while rst=0.
REQ-032 A reset during a word SHALL discard the remaining bits.
REQ-033 After reset is released, the first transmitted bit SHALL come from a newly loaded word only.

Verification
REQ-034 MSB-first: WIDTH=8, MSB_FIRST=1, shift_en=1 always, load 8'hA5 -> sout 1,0,1,0,0,1,0,1 on 8 consecutive cycles; sof on cycle 1, eof on cycle 8; then IDLE with sout_valid=0.
REQ-035 LSB-first: MSB_FIRST=0, load 8'hC1 -> sout 1,0,0,0,0,0,1,1; din_ready=0 for cycles 1-7 and 1 on cycle 8.
REQ-036 Back-to-back: din_valid held high with 8'hFF then 8'h00 -> 16 contiguous sout_valid cycles (eight 1s then eight 0s); sof at cycles 1 and 9, eof at cycles 8 and 16.
REQ-037 Rate control: shift_en high every 3rd cycle, load 8'h81 -> each bit held 3 cycles; bit_cnt and outputs frozen on shift_en=0 cycles; 24 cycles total.
REQ-038 Ignore while busy: load 8'hF0, then present din=8'h0F with din_valid=1 at bit 3 -> serial stream is still F0; 0F loads only at eof.
REQ-039 Reset mid-word: assert rst after 3 bits of 8'hA5 -> all outputs 0 before the next clock edge; after release din_ready=1, sout_valid=0, and no residual bits appear.
